mat_stream_tx: RTL and testbench
================================

// Module: mat_stream_tx
// PURPOSE
//  Streams a ROWS x COLS matrix out of a synchronous-read memory over an 8N1 UART line.
//  Each element is DATA_W wide and is sent as DATA_W/8 bytes; an optional header byte comes first.
//  Generalised successor of the single-matrix byte dump: parametrised size, width, byte order and baud.
//  Adds a clean busy/done handshake. Sits between a matrix memory read port and the board TX pin.
// PARAMETERS
//  ROWS        2            matrix rows (>=1)
//  COLS        2            matrix columns (>=1)
//  DATA_W      8            element width; multiple of 8, 8..32
//  ADDR_W      6            memory address width; elaboration error if ROWS*COLS > 2**ADDR_W
//  CLK_HZ      100_000_000  clk frequency
//  BAUD        9600         line rate; bit period DIV = CLK_HZ/BAUD cycles (integer division, DIV>=2)
//  MSB_FIRST   1            1: element's most significant byte sent first; 0: least significant first
//  HEADER_EN   0            1: send HEADER_BYTE once before the first element
//  HEADER_BYTE 8'hA5        header value
// PORTS
//  clk      in   1       system clock; all logic on posedge
//  rst      in   1       reset; synchronous, active-high
//  start    in   1       level input; a rising edge (sampled on clk) starts one matrix transfer
//  rd_en    out  1       memory read strobe, one cycle per element
//  rd_addr  out  ADDR_W  element address, row-major, 0..ROWS*COLS-1
//  rd_data  in   DATA_W  memory data, valid exactly 1 cycle after rd_en
//  tx_data  out  1       serial line, idles high
//  busy     out  1       high from the accepted start edge until done
//  done     out  1       one-cycle pulse after the last stop bit
// BEHAVIOUR
//  Reset: tx_data=1, busy=0, done=0, rd_en=0, rd_addr=0, state IDLE, all counters 0, start-edge reg=0.
//  Start detection: start_q <= start each cycle; edge = start & ~start_q.
//   Edges while busy are dropped, not queued. A start held high never re-triggers.
//  FSM states and transitions:
//   IDLE -> HDR if edge & HEADER_EN; IDLE -> FETCH if edge & ~HEADER_EN. busy goes high on the same edge.
//   HDR: present HEADER_BYTE to the serializer; when it is accepted -> FETCH.
//   FETCH: rd_en=1 for 1 cycle, rd_addr=idx -> WAIT_RD.
//   WAIT_RD: capture rd_data into elem_reg; byte_cnt=0 -> SEND.
//   SEND: present byte byte_cnt of elem_reg (per MSB_FIRST); on accept -> WAIT_TX.
//   WAIT_TX: when serializer ready:
//     if byte_cnt<BYTES-1: byte_cnt++ -> SEND
//     else if idx<N-1: idx++ -> FETCH
//     else -> FIN
//   FIN: done=1 for one cycle, busy=0, idx=0 -> IDLE.
//  Counter rules: idx counts 0..N-1 only and never wraps; N = ROWS*COLS.
//   For N=1 only address 0 is read. Unused upper rd_addr bits are 0.
//  Latency: edge sampled at cycle k; busy=1 at k+1; rd_en at k+1 (no header).
//   First start bit (tx_data low) by k+4. Consecutive frames are back-to-back with no idle bit.
//  Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held DIV cycles.
//   Serializer ready rises at the end of the stop bit.
//  Reset mid-operation: on the next edge tx_data=1 and busy=0, with no done pulse.
//   A partial frame is abandoned; the next start begins at element 0.
//  A start edge in the FIN cycle is ignored.
// STRUCTURE
//  Shared include uart_defs.vh: frame bit count (10), start/stop levels, DIV computation macro.
//  Sub-module uart_tx_core #(DIV): baud counter plus 10-bit shift register.
//   Ports: clk, rst, valid, byte, ready, tx.
//   Accepts when valid&ready; ready low for 10*DIV cycles.
//  Top level holds the start detector, FSM, idx/byte_cnt counters and elem_reg; state encoding is local.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, unless noted)
//  1 ROWS=COLS=2, DATA_W=8, mem={11,22,33,44}, start pulse
//    -> 4 frames 0x11,0x22,0x33,0x44, each 100 cycles; done once; busy spans them.
//  2 DATA_W=16, MSB_FIRST=1, mem[0]=ABCD, ROWS=COLS=1 -> frames AB then CD.
//    With MSB_FIRST=0 -> CD then AB.
//  3 HEADER_EN=1, mem={01,02,03,04} -> frames A5,01,02,03,04; rd_addr sequence 0,1,2,3 only.
//  4 Start re-pulsed mid-transfer and held high through done -> exactly 4 frames and 1 done.
//    No new transfer until start falls and rises again.
//  5 rst asserted during bit 4 of the second frame -> next cycle tx_data=1, busy=0, no done.
//    A following start sends 0x11 first.
//  6 Bit timing: each tx_data level held exactly 10 cycles.
//    rd_data checked 1 cycle after every rd_en.

Source files
------------

// File: rtl/mat_stream_tx_pkg.sv
// Shared UART framing constants and helpers for the matrix streamer.
`timescale 1ns/1ps
package mat_stream_tx_pkg;

    localparam int   FRAME_BITS = 10;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;
    localparam logic IDLE_LVL   = 1'b1;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Maps the transmit order position to the byte lane inside an element.
    function automatic int byte_sel(input int cnt, input int bytes, input bit msb_first);
        return msb_first ? (bytes - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/mat_stream_tx_if.sv
// Memory read port, start/busy/done handshake and serial line of the matrix streamer.
`timescale 1ns/1ps
interface mat_stream_tx_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              tx_data;
    logic              busy;
    logic              done;

    modport master (input start, rd_data, output rd_en, rd_addr, tx_data, busy, done);
    modport slave  (output start, rd_data, input rd_en, rd_addr, tx_data, busy, done);
endinterface

// File: rtl/mat_stream_tx_uart_tx_core.sv
// 8N1 serializer: baud counter plus 10-bit shift register, with back-to-back frame support.
`timescale 1ns/1ps
module uart_tx_core
    import mat_stream_tx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       tx
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    logic [DW-1:0]         div_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  active;
    logic                  last_tick;

    // Ready is raised in the final cycle of the stop bit so the next frame follows without an idle bit.
    assign last_tick = active && (bit_cnt == BIT_LAST) && (div_cnt == DIV_LAST);
    assign ready     = !active || last_tick;
    assign tx        = shreg[0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
        end else if (valid && ready) begin
            shreg   <= {STOP_LVL, tx_byte, START_LVL};
            active  <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                shreg   <= {IDLE_LVL, shreg[FRAME_BITS-1:1]};
                if (bit_cnt == BIT_LAST) active <= 1'b0;
                else                     bit_cnt <= bit_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/mat_stream_tx.sv
// Streams a ROWS x COLS matrix from a synchronous-read memory over an 8N1 UART line.
`timescale 1ns/1ps
module mat_stream_tx
    import mat_stream_tx_pkg::*;
#(
    parameter int         ROWS        = 2,
    parameter int         COLS        = 2,
    parameter int         DATA_W      = 8,
    parameter int         ADDR_W      = 6,
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         BAUD        = 9600,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter bit         HEADER_EN   = 1'b0,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input logic             clk,
    input logic             rst,
    mat_stream_tx_if.master bus
);
    localparam int N     = ROWS * COLS;
    localparam int BYTES = DATA_W / 8;
    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES - 1);

    if (ROWS < 1 || COLS < 1)                        begin : g_bad_dims  $error("ROWS and COLS must be >= 1"); end
    if (N > 2 ** ADDR_W)                             begin : g_bad_addr  $error("ROWS*COLS exceeds 2**ADDR_W"); end
    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 32) begin : g_bad_width $error("DATA_W must be 8, 16, 24 or 32"); end
    if (DIV < 2)                                     begin : g_bad_div   $error("CLK_HZ/BAUD must be >= 2"); end

    typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT_RD, SEND, WAIT_TX, FIN} state_t;

    state_t            state;
    logic              start_q;
    logic              start_edge;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] elem_reg;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_byte;

    assign start_edge  = bus.start & ~start_q;
    assign bus.rd_addr = idx;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_valid = (state == HDR) || (state == SEND);
        tx_byte  = 8'(elem_reg >> (8 * byte_sel(int'(byte_cnt), BYTES, MSB_FIRST)));
        if (state == HDR) tx_byte = HEADER_BYTE;
    end

    uart_tx_core #(.DIV(DIV)) u_core (
        .clk     (clk),
        .rst     (rst),
        .valid   (tx_valid),
        .tx_byte (tx_byte),
        .ready   (tx_ready),
        .tx      (bus.tx_data)
    );

    // Middle bytes skip waiting in WAIT_TX: the next byte is staged in SEND while the current frame shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            idx      <= '0;
            byte_cnt <= '0;
            elem_reg <= '0;
            bus.rd_en <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            start_q   <= bus.start;
            bus.rd_en <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    bus.busy <= 1'b1;
                    if (HEADER_EN) begin
                        state <= HDR;
                    end else begin
                        state     <= FETCH;
                        bus.rd_en <= 1'b1;
                    end
                end
                HDR: if (tx_ready) begin
                    state     <= FETCH;
                    bus.rd_en <= 1'b1;
                end
                FETCH: state <= WAIT_RD;
                WAIT_RD: begin
                    elem_reg <= bus.rd_data;
                    byte_cnt <= '0;
                    state    <= SEND;
                end
                SEND: if (tx_ready) state <= WAIT_TX;
                WAIT_TX: begin
                    if (byte_cnt != LAST_BYTE) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        state    <= SEND;
                    end else if (idx != LAST_IDX) begin
                        idx       <= idx + ADDR_W'(1);
                        state     <= FETCH;
                        bus.rd_en <= 1'b1;
                    end else if (tx_ready) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
                FIN: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_stream_tx.sv
// Scoreboard bench: four streamer configurations, frames decoded cycle by cycle off the serial line.
`timescale 1ns/1ps
module tb_mat_stream_tx;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] start_v;
    int checks   = 0;
    int failures = 0;
    int sel      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mat_stream_tx_if #(.ADDR_W(6), .DATA_W(8))  bus0 ();
    mat_stream_tx_if #(.ADDR_W(6), .DATA_W(16)) bus1 ();
    mat_stream_tx_if #(.ADDR_W(6), .DATA_W(16)) bus2 ();
    mat_stream_tx_if #(.ADDR_W(6), .DATA_W(8))  bus3 ();

    mat_stream_tx #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .CLK_HZ(1_000_000), .BAUD(100_000),
                    .MSB_FIRST(1'b1), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    mat_stream_tx #(.ROWS(1), .COLS(1), .DATA_W(16), .ADDR_W(6), .CLK_HZ(1_000_000), .BAUD(100_000),
                    .MSB_FIRST(1'b1), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    mat_stream_tx #(.ROWS(1), .COLS(1), .DATA_W(16), .ADDR_W(6), .CLK_HZ(1_000_000), .BAUD(100_000),
                    .MSB_FIRST(1'b0), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5))
        u2 (.clk(clk), .rst(rst), .bus(bus2));
    mat_stream_tx #(.ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .CLK_HZ(1_000_000), .BAUD(100_000),
                    .MSB_FIRST(1'b1), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5))
        u3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus3.start = start_v[3];

    // Memory models: data is X except exactly one cycle after rd_en.
    logic [7:0] mem0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] mem3 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    always @(posedge clk) begin
        bus0.rd_data <= (bus0.rd_en && bus0.rd_addr < 6'd4) ? mem0[bus0.rd_addr[1:0]] : 'x;
        bus3.rd_data <= (bus3.rd_en && bus3.rd_addr < 6'd4) ? mem3[bus3.rd_addr[1:0]] : 'x;
        bus1.rd_data <= (bus1.rd_en && bus1.rd_addr == 6'd0) ? 16'hABCD : 'x;
        bus2.rd_data <= (bus2.rd_en && bus2.rd_addr == 6'd0) ? 16'hABCD : 'x;
    end

    logic       m_tx, m_busy, m_done, m_rd_en;
    logic [5:0] m_addr;
    always_comb begin
        m_tx = bus0.tx_data; m_busy = bus0.busy; m_done = bus0.done; m_rd_en = bus0.rd_en; m_addr = bus0.rd_addr;
        case (sel)
            1: begin m_tx = bus1.tx_data; m_busy = bus1.busy; m_done = bus1.done; m_rd_en = bus1.rd_en; m_addr = bus1.rd_addr; end
            2: begin m_tx = bus2.tx_data; m_busy = bus2.busy; m_done = bus2.done; m_rd_en = bus2.rd_en; m_addr = bus2.rd_addr; end
            3: begin m_tx = bus3.tx_data; m_busy = bus3.busy; m_done = bus3.done; m_rd_en = bus3.rd_en; m_addr = bus3.rd_addr; end
            default: ;
        endcase
    end

    logic [7:0] exp_q  [$];
    logic [5:0] addr_q [$];
    always @(negedge clk) begin
        if (m_rd_en === 1'b1) addr_q.push_back(m_addr);
        if (m_done === 1'b1)  done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the first start bit, then samples nframes*100 consecutive cycles (frames must abut).
    task automatic rx_transfer(input int nframes, input int lat_max, input string tag);
        logic       fs [100];
        logic [7:0] b, exp;
        bit         seen, shape_ok, busy_ok;
        int         lat;
        seen = 0; lat = 0; busy_ok = 1;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (m_tx === 1'b0) seen = 1;
        end
        check({tag, "_start_seen"}, 32'(seen), 1);
        if (!seen) return;
        if (lat_max > 0) check({tag, "_latency_ok"}, 32'(lat <= lat_max), 1);
        for (int c = 0; c < nframes * 100; c++) begin
            if (c > 0) @(negedge clk);
            fs[c % 100] = m_tx;
            if (m_busy !== 1'b1) busy_ok = 0;
            if (c % 100 == 99) begin
                for (int i = 0; i < 8; i++) b[i] = fs[10 * (i + 1) + 5];
                shape_ok = (fs[5] === 1'b0) && (fs[95] === 1'b1);
                for (int j = 0; j < 100; j++)
                    if (fs[j] !== fs[(j / 10) * 10 + 5]) shape_ok = 0;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check({tag, "_byte"}, 32'(b), 32'(exp));
                check({tag, "_bit_timing"}, 32'(shape_ok), 1);
            end
        end
        check({tag, "_busy_span"}, 32'(busy_ok), 1);
        check({tag, "_frames_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(m_done), 1);
        check({tag, "_busy_low"}, 32'(m_busy), 0);
        @(negedge clk);
        check({tag, "_done_single"}, 32'(m_done), 0);
    endtask

    task automatic run(input int s, input int nframes, input int n_addrs, input bit repulse, input string tag);
        int d0;
        sel = s;
        addr_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        check({tag, "_busy_k1"}, 32'(m_busy), 1);
        check({tag, "_rd_en_k1"}, 32'(m_rd_en), (s == 3) ? 0 : 1);
        if (!repulse) start_v[s] = 1'b0;
        fork
            rx_transfer(nframes, 3, tag);
            if (repulse) begin
                repeat (150) @(negedge clk);
                start_v[s] = 1'b0;
                @(negedge clk);
                start_v[s] = 1'b1;
            end
        join
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_addr_count"}, addr_q.size(), n_addrs);
        for (int i = 0; i < n_addrs && i < addr_q.size(); i++)
            check({tag, "_addr"}, 32'(addr_q[i]), i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int  d0;
        bit  quiet, seen;
        rst = 1'b1;
        start_v = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(m_tx), 1);
        check("reset_busy", 32'(m_busy), 0);
        check("reset_done", 32'(m_done), 0);
        check("reset_rd_en", 32'(m_rd_en), 0);
        check("reset_rd_addr", 32'(m_addr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2x2 byte matrix
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(0, 4, 4, 1'b0, "t1");

        // 16-bit element, both byte orders
        exp_q = '{8'hAB, 8'hCD};
        run(1, 2, 1, 1'b0, "t2_msb");
        exp_q = '{8'hCD, 8'hAB};
        run(2, 2, 1, 1'b0, "t2_lsb");

        // header byte ahead of elements
        exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        run(3, 5, 4, 1'b0, "t3_hdr");

        // re-pulse mid-transfer and hold start high through done
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(0, 4, 4, 1'b1, "t4");
        d0 = done_cnt;
        quiet = 1;
        repeat (300) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_rd_en !== 1'b0) quiet = 0;
        end
        check("t4_held_no_retrigger", 32'(quiet), 1);
        check("t4_held_no_done", done_cnt - d0, 0);
        start_v[0] = 1'b0;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(0, 4, 4, 1'b0, "t4_rearm");

        // reset during frame-bit 4 of the second frame (0x22: that bit is low)
        sel = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (m_tx === 1'b0) seen = 1;
        end
        check("t5_start_seen", 32'(seen), 1);
        start_v[0] = 1'b0;
        repeat (145) @(negedge clk);
        check("t5_pre_reset_tx", 32'(m_tx), 0);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_tx", 32'(m_tx), 1);
        check("t5_reset_busy", 32'(m_busy), 0);
        rst = 1'b0;
        quiet = 1;
        repeat (200) begin
            @(negedge clk);
            if (m_tx !== 1'b1 || m_busy !== 1'b0) quiet = 0;
        end
        check("t5_idle_after_reset", 32'(quiet), 1);
        check("t5_no_done", done_cnt - d0, 0);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(0, 4, 4, 1'b0, "t5_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
